// File: rtl/connect4_pkg.sv
// Shared Connect4 definitions: board geometry, game status codes and the
// column input controller state encoding.
package connect4_pkg;

   localparam int NUM_COLS     = 4;
   localparam int NUM_ROWS     = 4;
   localparam int TOP_ROW_BASE = 12;

   localparam logic [1:0] ST_PLAYING = 2'b00;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ISSUE    = 2'd1,
      WAIT_ACK = 2'd2
   } ctrl_state_e;

   function automatic logic [3:0] col_onehot(input logic [1:0] col);
      col_onehot      = '0;
      col_onehot[col] = 1'b1;
   endfunction

endpackage

// File: rtl/column_input_controller_button_debouncer.sv
// Raw pushbutton conditioning: 2-FF synchronizer, stability counter and a
// registered one-cycle pulse on each rising edge of the debounced level.
module button_debouncer #(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic rise
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          sync1;
   logic          sync2;
   logic          level;
   logic          level_q;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         level   <= 1'b0;
         level_q <= 1'b0;
         rise    <= 1'b0;
         cnt     <= '0;
      end else begin
         sync1   <= btn;
         sync2   <= sync1;
         level_q <= level;
         rise    <= level & ~level_q;
         // Any sample agreeing with the current level restarts the count.
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            level <= sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/column_input_controller.sv
// Connect4 column-select front end: debounced cursor/drop buttons to a
// single registered move strobe, with gameboard-change acknowledge.
module column_input_controller
   import connect4_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned ACK_TIMEOUT     = 64,
   parameter int unsigned NUM_COLS        = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic        btn_drop,
   input  logic [15:0] in_gameboard,
   input  logic [1:0]  in_game_status,
   output logic [3:0]  out_column,
   output logic        out_enable,
   output logic [3:0]  cursor_leds,
   output logic        busy,
   output logic        ack_error
);

   localparam int unsigned CUR_W = $clog2(NUM_COLS);
   localparam int unsigned TW    = $clog2(ACK_TIMEOUT + 1);

   ctrl_state_e         state, state_n;
   logic [CUR_W-1:0]    cursor, cursor_n;
   logic [TW-1:0]       ack_cnt, ack_cnt_n;
   logic [15:0]         snapshot;
   logic [NUM_COLS-1:0] top_row;
   logic                left_p, right_p, drop_p;
   logic                col_full;
   logic                issue;
   logic                timeout;

   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
      .clk   (clk),
      .reset (reset),
      .btn   (btn_left),
      .rise  (left_p)
   );

   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
      .clk   (clk),
      .reset (reset),
      .btn   (btn_right),
      .rise  (right_p)
   );

   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_drop (
      .clk   (clk),
      .reset (reset),
      .btn   (btn_drop),
      .rise  (drop_p)
   );

   assign top_row  = in_gameboard[TOP_ROW_BASE +: NUM_COLS];
   assign col_full = top_row[cursor];
   assign busy     = (state == ISSUE) || (state == WAIT_ACK);

   always_comb begin
      state_n   = state;
      cursor_n  = cursor;
      ack_cnt_n = ack_cnt;
      issue     = 1'b0;
      timeout   = 1'b0;
      case (state)
         IDLE: begin
            ack_cnt_n = '0;
            // A drop pulse always suppresses cursor movement, legal or not.
            if (drop_p) begin
               if (!col_full && (in_game_status == ST_PLAYING)) begin
                  state_n = ISSUE;
                  issue   = 1'b1;
               end
            end else if (left_p && !right_p) begin
               cursor_n = (cursor == '0) ? CUR_W'(NUM_COLS - 1) : cursor - 1'b1;
            end else if (right_p && !left_p) begin
               cursor_n = (cursor == CUR_W'(NUM_COLS - 1)) ? '0 : cursor + 1'b1;
            end
         end
         ISSUE: begin
            state_n   = WAIT_ACK;
            ack_cnt_n = '0;
         end
         WAIT_ACK: begin
            if (in_gameboard != snapshot) begin
               state_n   = IDLE;
               ack_cnt_n = '0;
            end else if (ack_cnt == TW'(ACK_TIMEOUT - 1)) begin
               state_n   = IDLE;
               ack_cnt_n = '0;
               timeout   = 1'b1;
            end else begin
               ack_cnt_n = ack_cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         cursor      <= '0;
         ack_cnt     <= '0;
         snapshot    <= '0;
         out_column  <= '0;
         out_enable  <= 1'b0;
         cursor_leds <= 4'b0001;
         ack_error   <= 1'b0;
      end else begin
         state       <= state_n;
         cursor      <= cursor_n;
         ack_cnt     <= ack_cnt_n;
         out_enable  <= issue;
         cursor_leds <= col_onehot(2'(cursor));
         ack_error   <= ack_error | timeout;
         if (issue) begin
            out_column <= 4'(cursor);
         end
         // The strobe is visible during ISSUE; the board is captured as it leaves.
         if (state == ISSUE) begin
            snapshot <= in_gameboard;
         end
      end
   end

endmodule

// File: tb/tb_column_input_controller.sv
// Randomized scoreboard bench for column_input_controller: a button-level
// reference model predicts each issued column and the cursor/error state.
module tb_column_input_controller;

   localparam int DB  = 16;
   localparam int ACK = 64;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        btn_left = 1'b0;
   logic        btn_right = 1'b0;
   logic        btn_drop = 1'b0;
   logic [15:0] in_gameboard;
   logic [1:0]  in_game_status = 2'b00;
   logic [3:0]  out_column;
   logic        out_enable;
   logic [3:0]  cursor_leds;
   logic        busy;
   logic        ack_error;

   logic [3:0]  top_row = 4'b0000;
   logic [3:0]  low_row = 4'b0000;
   bit          ack_change = 1'b1;

   int          n_checks = 0;
   int          n_pass = 0;
   int          exp_q[$];
   int          m_cur = 0;
   int          m_err = 0;
   int          m_last_col = 0;

   assign in_gameboard = {top_row, 8'h00, low_row};

   column_input_controller #(
      .DEBOUNCE_CYCLES (DB),
      .ACK_TIMEOUT     (ACK),
      .NUM_COLS        (4)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .btn_left       (btn_left),
      .btn_right      (btn_right),
      .btn_drop       (btn_drop),
      .in_gameboard   (in_gameboard),
      .in_game_status (in_game_status),
      .out_column     (out_column),
      .out_enable     (out_enable),
      .cursor_leds    (cursor_leds),
      .busy           (busy),
      .ack_error      (ack_error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: every strobe must match the oldest predicted move.
   always @(negedge clk) begin
      if (reset && out_enable) begin
         chk("busy_at_strobe", int'(busy), 1);
         if (exp_q.size() == 0) begin
            chk("unexpected_strobe_col", int'(out_column), -1);
         end else begin
            chk("strobe_column", int'(out_column), exp_q.pop_front());
         end
      end
   end

   // Gameboard responder: acknowledges a move three cycles after the strobe.
   always @(negedge clk) begin
      if (reset && out_enable && ack_change) begin
         repeat (3) @(posedge clk);
         #1;
         low_row = low_row ^ 4'(1 << $urandom_range(0, 3));
      end
   end

   task automatic press(input bit l, input bit r, input bit d, input int hold);
      btn_left  = l;
      btn_right = r;
      btn_drop  = d;
      cycles(hold);
      btn_left  = 1'b0;
      btn_right = 1'b0;
      btn_drop  = 1'b0;
      cycles(DB + 10);
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_leds"}, int'(cursor_leds), 1 << m_cur);
      chk({tag, "_ack_error"}, int'(ack_error), m_err);
      chk({tag, "_busy"}, int'(busy), 0);
   endtask

   task automatic op_left();
      press(1, 0, 0, DB + 8);
      m_cur = (m_cur + 3) % 4;
      check_idle("left");
   endtask

   task automatic op_right();
      press(0, 1, 0, DB + 8);
      m_cur = (m_cur + 1) % 4;
      check_idle("right");
   endtask

   task automatic op_both();
      press(1, 1, 0, DB + 8);
      check_idle("both");
   endtask

   task automatic op_bounce();
      int k;
      int n;
      k = $urandom_range(1, DB - 4);
      n = 2 * $urandom_range(3, 8);
      for (int i = 0; i < n; i++) begin
         btn_right = ~btn_right;
         cycles(k);
      end
      btn_right = 1'b0;
      cycles(DB + 10);
      check_idle("bounce");
   endtask

   task automatic op_drop(input bit change, input int hold);
      ack_change = change;
      if (!top_row[m_cur] && in_game_status == 2'b00) begin
         exp_q.push_back(m_cur);
         m_last_col = m_cur;
         if (!change) m_err = 1;
      end
      press(0, 0, 1, hold);
      cycles(ACK + 10);
      check_idle("drop");
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_leds", int'(cursor_leds), 4'b0001);
      chk("rst_enable", int'(out_enable), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_ack_error", int'(ack_error), 0);
      chk("rst_column", int'(out_column), 0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      cycles(3);

      // Directed: wrap, bounce, legal drop, refused drops, timeout.
      op_left();
      op_right();
      op_bounce();
      op_right();
      op_right();
      op_drop(1'b1, 100);
      chk("col_hold", int'(out_column), 2);
      op_left();
      top_row = 4'b0010;
      op_drop(1'b1, 40);
      top_row = 4'b0000;
      in_game_status = 2'b01;
      op_drop(1'b1, 40);
      in_game_status = 2'b00;
      op_drop(1'b0, 40);
      chk("timeout_sticky", int'(ack_error), 1);
      op_drop(1'b1, 40);

      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 5))
            0: op_left();
            1: op_right();
            2: op_both();
            3: op_bounce();
            default: begin
               top_row        = 4'($urandom & $urandom);
               in_game_status = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
               op_drop(($urandom_range(0, 3) != 0), $urandom_range(DB + 8, 100));
               in_game_status = 2'b00;
            end
         endcase
      end
      chk("col_hold_final", int'(out_column), m_last_col);

      // Reset in the middle of an acknowledge wait.
      top_row    = 4'b0000;
      ack_change = 1'b0;
      exp_q.push_back(m_cur);
      btn_drop = 1'b1;
      cycles(DB + 14);
      chk("mid_busy", int'(busy), 1);
      reset    = 1'b0;
      btn_drop = 1'b0;
      m_cur = 0;
      m_err = 0;
      @(negedge clk);
      chk("mid_rst_leds", int'(cursor_leds), 4'b0001);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_ack_error", int'(ack_error), 0);
      chk("mid_rst_column", int'(out_column), 0);
      chk("mid_rst_enable", int'(out_enable), 0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      cycles(DB + 10);
      check_idle("post_rst");

      chk("pending_moves", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/column_input_controller.md
Name: column_input_controller

Overview:
- Front end for the Connect4 column-select path: turns three raw pushbuttons (left, right, drop) into the in_column/enable move request consumed by the column-select circuit.
- Keeps a cursor over the 4 columns and refuses drops into full columns or after the game ends.
- After issuing a move, waits for the gameboard to change (acknowledge) before it accepts another drop.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable synchronized samples needed to accept a button level change.
- ACK_TIMEOUT, 64, cycles to wait in WAIT_ACK for a gameboard change before giving up.
- NUM_COLS, 4, board columns; cursor range 0..NUM_COLS-1.

Ports:
- clk  input  1  system clock, single domain
- reset  input  1  asynchronous, active-low reset
- btn_left  input  1  raw asynchronous button, active-high
- btn_right  input  1  raw asynchronous button, active-high
- btn_drop  input  1  raw asynchronous button, active-high
- in_gameboard  input  16  occupancy, 1=occupied; cell index = row*4+col, row 0 = bottom
- in_game_status  input  2  00 = playing; any other value = game over
- out_column  output  4  selected column 0..3, zero-extended
- out_enable  output  1  one-cycle move request strobe
- cursor_leds  output  4  one-hot cursor position
- busy  output  1  high in ISSUE and WAIT_ACK
- ack_error  output  1  sticky; set on ACK_TIMEOUT expiry

Behaviour:
- Reset (reset=0, async) values: cursor=0, out_column=0, out_enable=0, cursor_leds=4'b0001, busy=0, ack_error=0, state=IDLE, all debouncers low.
- Input conditioning: each button passes a 2-FF synchronizer, then a debounce counter. The debounced level changes only after DEBOUNCE_CYCLES consecutive samples differ from it. A rising-edge detector on the debounced level gives one-cycle left_p, right_p and drop_p pulses.
- Latency from a raw button edge to its pulse is 2 + DEBOUNCE_CYCLES + 1 cycles.
- Column full: column c is full when in_gameboard[12+c] = 1.
- IDLE:
  - drop_p, column not full and in_game_status=00 -> ISSUE.
  - Else if left_p and not right_p: cursor = cursor-1, wrapping 0 -> 3.
  - Else if right_p and not left_p: cursor = cursor+1, wrapping 3 -> 0.
  - left_p and right_p in the same cycle: ignored.
  - drop_p together with left_p or right_p: the drop is evaluated and the cursor is not moved.
  - drop_p into a full column, or while game over: ignored, state stays IDLE.
- ISSUE, exactly 1 cycle:
  - out_enable=1; out_column = cursor registered in this cycle.
  - Snapshot in_gameboard into an internal register.
  - -> WAIT_ACK.
- WAIT_ACK:
  - out_enable=0; a timeout counter increments from 0.
  - in_gameboard != snapshot -> IDLE; counter cleared.
  - Counter reaches ACK_TIMEOUT-1 with no change -> set ack_error, -> IDLE.
  - Button pulses are discarded; the cursor is frozen.
- out_column holds its last issued value between moves.
- cursor_leds = one-hot of cursor and updates in the cycle after the cursor changes.
- ack_error clears only on reset.
- in_game_status leaving 00 while in WAIT_ACK: the ack wait still completes normally, and no further drops are accepted.
- Reset asserted mid-operation: returns immediately to the reset values. No out_enable glitch: out_enable is a registered output.
- A held drop button yields exactly one move; a second move requires release plus re-press.

Decomposition:
- Shared package connect4_pkg:
  - NUM_COLS=4, NUM_ROWS=4, TOP_ROW_BASE=12.
  - Game status codes: ST_PLAYING=2'b00.
  - State encoding for this block: IDLE=2'd0, ISSUE=2'd1, WAIT_ACK=2'd2.
- Sub-module button_debouncer (parameter DEBOUNCE_CYCLES): synchronizer, counter and rise pulse output. Instantiated three times.

Test Plan:
- Reset: hold reset=0 for 3 cycles -> cursor_leds=0001, out_enable=0, busy=0, ack_error=0.
- Cursor wrap: at cursor=0, press btn_left once (stable > DEBOUNCE_CYCLES) -> cursor_leds=1000; then press btn_right -> 0001.
- Bounce rejection: toggle btn_right every 5 cycles for 60 cycles, then release -> cursor unchanged, no out_enable.
- Legal drop:
  - Stimulus: cursor=2, empty board, status=00; hold btn_drop for 100 cycles; TB sets in_gameboard[2]=1 three cycles after the strobe.
  - Required: exactly one out_enable pulse with out_column=4'd2; busy high until the board changes, then low; no second pulse.
- Full column / game over: in_gameboard[13]=1 with cursor=1, press drop -> no out_enable; status=2'b01 with an empty board, press drop -> no out_enable.
- Ack timeout: drop with the board held constant -> after ACK_TIMEOUT cycles ack_error=1, state IDLE. Next valid drop still issues; ack_error remains 1.
